// File: rtl/radix4_seq_divider.sv
// Sequential radix-4 restoring divider: unsigned N-bit x / y, two quotient bits per cycle.
// Optional APPROX_DIV_EN: stop after N/2-A digits and force the low 2A quotient bits to zero.
module radix4_seq_divider #(
  parameter int N = 16,
  parameter int A = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         dz
);

`ifdef APPROX_DIV_EN
  localparam int SKIP = A;
`else
  localparam int SKIP = 0;
`endif
  localparam int STEPS = N/2 - SKIP;
  localparam int CW    = $clog2(N/2 + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state, state_nxt;
  logic [N+1:0] d1, d2, d3;
  logic [N+1:0] t, sub;
  logic [N-1:0] xr, rem, qr;
  logic [N-1:0] rem_nxt, q_nxt, xs;
  logic [1:0]   dig;
  logic [CW-1:0] cnt;
  logic         dzr;
  logic         accept;

  assign accept = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (y == '0) ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = start ? ((y == '0) ? DONE : CALC) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
    q    = qr;
    r    = rem;
    dz   = dzr;
  end

  // One restoring radix-4 step: pick the largest multiple of D not exceeding T.
  always_comb begin
    t = {rem, xr[N-1:N-2]};
    if (t >= d3) begin
      dig = 2'd3;
      sub = d3;
    end else if (t >= d2) begin
      dig = 2'd2;
      sub = d2;
    end else if (t >= d1) begin
      dig = 2'd1;
      sub = d1;
    end else begin
      dig = 2'd0;
      sub = '0;
    end
    rem_nxt = N'(t - sub);
    q_nxt   = {qr[N-3:0], dig};
    xs      = {xr[N-3:0], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr  <= '0;
      d1  <= '0;
      d2  <= '0;
      d3  <= '0;
      rem <= '0;
      qr  <= '0;
      cnt <= '0;
      dzr <= 1'b0;
    end else if (accept) begin
      cnt <= CW'(STEPS);
      if (y == '0) begin
        xr  <= '0;
        d1  <= '0;
        d2  <= '0;
        d3  <= '0;
        qr  <= '1;
        rem <= x;
        dzr <= 1'b1;
      end else begin
        xr  <= x;
        d1  <= {2'b00, y};
        d2  <= {1'b0, y, 1'b0};
        d3  <= {2'b00, y} + {1'b0, y, 1'b0};
        qr  <= '0;
        rem <= '0;
        dzr <= 1'b0;
      end
    end else if (state == CALC) begin
      xr  <= xs;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        // Skipped digits: quotient low bits are zero, unconsumed dividend bits join the remainder.
        qr  <= q_nxt << (2*SKIP);
        rem <= N'({rem_nxt, xs} >> (N - 2*SKIP));
      end else begin
        qr  <= q_nxt;
        rem <= rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_radix4_seq_divider.sv
// Directed self-checking bench for radix4_seq_divider (N=16, A=2); vector table plus
// hand-written sequences for CALC-time start, back-to-back ops and mid-CALC reset.
module tb_radix4_seq_divider;

  localparam int N = 16;
`ifdef APPROX_DIV_EN
  localparam int CALC_EDGES = 6;
`else
  localparam int CALC_EDGES = 8;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  x = '0;
  logic [N-1:0]  y = '0;
  logic          busy, done, dz;
  logic [N-1:0]  q, r;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[$];

  radix4_seq_divider #(.N(N), .A(2)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .q(q), .r(r), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op, return edges from acceptance to done and busy cycles seen.
  task automatic do_op(input logic [N-1:0] xv, input logic [N-1:0] yv,
                       output int lat, output int bcyc,
                       output logic [N-1:0] acc_q, output logic acc_dz);
    @(negedge clk);
    x = xv; y = yv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    acc_q = q; acc_dz = dz;
    lat = 0; bcyc = 0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) chk("timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int lat, bcyc;
    logic [N-1:0] aq;
    logic adz;

`ifdef APPROX_DIV_EN
    vecs.push_back('{16'd1000,   16'd7,      16'd128,    16'd104,    1'b0});
    vecs.push_back('{16'd100,    16'd7,      16'd0,      16'd100,    1'b0});
    vecs.push_back('{16'h1234,   16'd0,      16'hFFFF,   16'h1234,   1'b1});
    vecs.push_back('{16'hFFFF,   16'd1,      16'hFFF0,   16'h000F,   1'b0});
`else
    vecs.push_back('{16'd100,    16'd7,      16'd14,     16'd2,      1'b0});
    vecs.push_back('{16'hFFFF,   16'd1,      16'hFFFF,   16'd0,      1'b0});
    vecs.push_back('{16'd5,      16'd9,      16'd0,      16'd5,      1'b0});
    vecs.push_back('{16'h1234,   16'd0,      16'hFFFF,   16'h1234,   1'b1});
    vecs.push_back('{16'hFFFF,   16'hFFFF,   16'd1,      16'd0,      1'b0});
    vecs.push_back('{16'd1000,   16'd7,      16'd142,    16'd6,      1'b0});
    vecs.push_back('{16'h8000,   16'd3,      16'h2AAA,   16'd2,      1'b0});
`endif

    // Reset state, including start held during reset.
    start = 1'b1; x = 16'd100; y = 16'd7;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;

    // Vector table, issued back-to-back (each start lands in the DONE cycle).
    foreach (vecs[i]) begin
      do_op(vecs[i].x, vecs[i].y, lat, bcyc, aq, adz);
      chk($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("v%0d_r", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("v%0d_dz", i), 32'(dz), 32'(vecs[i].dz));
      chk($sformatf("v%0d_lat", i), 32'(lat), vecs[i].dz ? 32'd0 : 32'(CALC_EDGES));
      chk($sformatf("v%0d_busy", i), 32'(bcyc), vecs[i].dz ? 32'd0 : 32'(CALC_EDGES));
      if (!vecs[i].dz) begin
        chk($sformatf("v%0d_acc_q", i), 32'(aq), 32'd0);
        chk($sformatf("v%0d_acc_dz", i), 32'(adz), 32'd0);
      end
    end

    // done is a single-cycle pulse; results hold afterwards.
    @(posedge clk); #1;
    chk("pulse_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("hold_q", 32'(q), 32'(vecs[vecs.size()-1].q));

    // start and new operands during CALC are ignored.
    @(negedge clk);
    x = 16'd100; y = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    x = 16'hFFFF; y = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("calc_start_lat", 32'(lat), 32'(CALC_EDGES));
`ifdef APPROX_DIV_EN
    chk("calc_start_q", 32'(q), 32'd0);
    chk("calc_start_r", 32'(r), 32'd100);
`else
    chk("calc_start_q", 32'(q), 32'd14);
    chk("calc_start_r", 32'(r), 32'd2);
`endif

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    x = 16'd1000; y = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_q", 32'(q), 32'd0);
    chk("mid_rst_r", 32'(r), 32'd0);
    chk("mid_rst_dz", 32'(dz), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'd100, 16'd7, lat, bcyc, aq, adz);
    chk("post_rst_lat", 32'(lat), 32'(CALC_EDGES));
`ifdef APPROX_DIV_EN
    chk("post_rst_q", 32'(q), 32'd0);
    chk("post_rst_r", 32'(r), 32'd100);
`else
    chk("post_rst_q", 32'(q), 32'd14);
    chk("post_rst_r", 32'(r), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
